// File: rtl/output_drain_pkg.sv
// Shared types and constants for the output drain controller.
package output_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/output_drain_ctrl_if.sv
// Result stream valid/ready bundle between the drain controller and its consumer.
interface output_drain_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic              m_valid_out;
  logic              m_ready_in;
  logic [DATA_W-1:0] m_data_out;
  logic              m_last_out;

  modport master (
    output m_valid_out,
    output m_data_out,
    output m_last_out,
    input  m_ready_in
  );

  modport slave (
    input  m_valid_out,
    input  m_data_out,
    input  m_last_out,
    output m_ready_in
  );

endinterface

// File: rtl/drain_fifo2.sv
// Two-entry FIFO whose head entry is a register, so the stream outputs are glitch-free.
module drain_fifo2
  import output_drain_pkg::*;
#(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  localparam logic [1:0] FULL_OCC = 2'(BUF_DEPTH);

  logic              head_vld;
  logic              tail_vld;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;

  assign occ       = 2'(head_vld) + 2'(tail_vld);
  assign full      = (occ == FULL_OCC);
  assign empty     = !head_vld;
  assign head_data = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!head_vld) begin
            head_q   <= push_data;
            head_vld <= 1'b1;
          end else begin
            tail_q   <= push_data;
            tail_vld <= 1'b1;
          end
        end
        2'b01: begin
          if (tail_vld) begin
            head_q   <= tail_q;
            tail_vld <= 1'b0;
          end else begin
            head_vld <= 1'b0;
          end
        end
        // pop implies a valid head, so the head stays valid on push+pop
        2'b11: begin
          if (tail_vld) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/output_drain_ctrl.sv
// Reads a contiguous block from the result memory and streams it out with valid/ready.
module output_drain_ctrl
  import output_drain_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [ADDR_W-1:0]      base_addr_in,
  input  logic [ADDR_W:0]        count_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [ADDR_W-1:0]      mem_raddr_out,
  input  logic                   mem_we_in,
  input  logic [DATA_W-1:0]      mem_rdata_in,
  output_drain_ctrl_if.master    strm
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   popped_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              accept;
  logic              issue;
  logic              issue_last;
  logic              pop;
  logic [2:0]        pending;
  logic [1:0]        occ;
  logic              full;
  logic              empty;
  logic [DATA_W:0]   head;

  assign accept     = (state_q == IDLE) && start_in;
  assign pop        = strm.m_valid_out && strm.m_ready_in;
  assign issue_last = (issued_q == count_q - ONE);

  // Credit: words buffered plus the read in flight, minus what leaves this cycle, must stay below 2.
  assign pending = 3'(occ) + 3'(inflight_q);
  assign issue   = (state_q == DRAIN) && !mem_we_in && (issued_q < count_q) &&
                   (pending < 3'd2 + 3'(pop));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = (count_in == '0) ? DONE : DRAIN;
      DRAIN:   if (popped_q == count_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: address, counters and the one-deep in-flight marker for the registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      popped_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (accept) begin
        addr_q   <= base_addr_in;
        count_q  <= count_in;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + 1'b1;
          issued_q <= issued_q + ONE;
        end
        if (pop) popped_q <= popped_q + ONE;
      end
    end
  end

  // Capture stage: read data is valid only in the cycle after its issue
  drain_fifo2 #(
    .DATA_W (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_rdata_in}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .occ       (occ),
    .head_data (head)
  );

  assign strm.m_valid_out = !empty;
  assign strm.m_data_out  = head[DATA_W-1:0];
  assign strm.m_last_out  = head[DATA_W] && !empty;

  assign busy_out      = (state_q == DRAIN);
  assign done_out      = (state_q == DONE);
  assign mem_raddr_out = addr_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inflight_q && full && !pop));

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl with a registered-read memory model.
module tb_output_drain_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic [ADDR_W:0]   count_in;
  logic              busy_out;
  logic              done_out;
  logic [ADDR_W-1:0] mem_raddr_out;
  logic              mem_we_in;
  logic [DATA_W-1:0] mem_rdata_in;

  output_drain_ctrl_if #(.DATA_W(DATA_W)) strm ();

  output_drain_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .base_addr_in  (base_addr_in),
    .count_in      (count_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .mem_raddr_out (mem_raddr_out),
    .mem_we_in     (mem_we_in),
    .mem_rdata_in  (mem_rdata_in),
    .strm          (strm)
  );

  always #5 clk = ~clk;

  // Memory: registered read, rdata holds while a write is in progress
  logic [DATA_W-1:0] mem [0:MEM_N-1];
  initial begin
    for (int k = 0; k < MEM_N; k++) mem[k] = 32'(k + 32'h100);
    mem_rdata_in = '0;
  end
  always @(posedge clk) if (!mem_we_in) mem_rdata_in <= mem[mem_raddr_out];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W:0] beats[$];
  int              done_cnt = 0;
  int              done_cyc = -1;
  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_word = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        chk("hold", {strm.m_valid_out, strm.m_last_out, strm.m_data_out}, {1'b1, prev_word});
      if (strm.m_valid_out) chk("occ_le2", 64'(dut.occ <= 2'd2), 64'd1);
      if (strm.m_valid_out && strm.m_ready_in)
        beats.push_back({strm.m_last_out, strm.m_data_out});
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = strm.m_valid_out && !strm.m_ready_in;
      prev_word  = {strm.m_last_out, strm.m_data_out};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_beats(input string tag, input int base, input int cnt);
    logic [DATA_W:0] exp;
    chk({tag, "_n"}, 64'(beats.size()), 64'(cnt));
    for (int i = 0; i < beats.size() && i < cnt; i++) begin
      exp = {(i == cnt - 1), 32'(((base + i) % MEM_N) + 32'h100)};
      chk({tag, "_beat"}, 64'(beats[i]), 64'(exp));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy_out), 64'd0);
    chk({tag, "_done"},  64'(done_out), 64'd0);
    chk({tag, "_valid"}, 64'(strm.m_valid_out), 64'd0);
    chk({tag, "_last"},  64'(strm.m_last_out), 64'd0);
    chk({tag, "_data"},  64'(strm.m_data_out), 64'd0);
    chk({tag, "_raddr"}, 64'(mem_raddr_out), 64'd0);
  endtask

  // mode 1: ready follows 1,0,0,1,... from the cycle after start
  task automatic run_drain(input int base, input int cnt, input int mode,
                           input int we_lo, input int we_hi, input int restart_at,
                           output int lat);
    int                c0;
    int                off;
    bit                seen;
    logic              we_prev;
    logic [ADDR_W-1:0] ra_prev;
    beats.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    base_addr_in = ADDR_W'(base);
    count_in     = (ADDR_W+1)'(cnt);
    start_in     = 1'b1;
    c0           = cyc;
    seen         = 1'b0;
    we_prev      = 1'b0;
    ra_prev      = '0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      off = cyc - c0;
      if (we_prev) chk("raddr_hold", 64'(mem_raddr_out), 64'(ra_prev));
      ra_prev  = mem_raddr_out;
      start_in = (off == restart_at);
      if (start_in) begin
        base_addr_in = '0;
        count_in     = (ADDR_W+1)'(1);
      end
      mem_we_in       = (off >= we_lo) && (off <= we_hi);
      we_prev         = mem_we_in;
      strm.m_ready_in = (mode == 1) ? ((off % 3) == 1) : 1'b1;
      if (done_cyc >= 0) seen = 1'b1;
    end
    start_in        = 1'b0;
    mem_we_in       = 1'b0;
    strm.m_ready_in = 1'b1;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    lat = done_cyc - c0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst             = 1'b1;
    start_in        = 1'b0;
    base_addr_in    = '0;
    count_in        = '0;
    mem_we_in       = 1'b0;
    strm.m_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // basic drain
    run_drain(4, 3, 0, -1, -1, -1, lat);
    check_beats("basic", 4, 3);
    chk("basic_lat", 64'(lat), 64'd7);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("idle_busy", 64'(busy_out), 64'd0);

    // backpressure
    run_drain(100, 4, 1, -1, -1, -1, lat);
    check_beats("bp", 100, 4);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);

    // write interference mid-drain
    run_drain(10, 6, 0, 3, 5, -1, lat);
    check_beats("we", 10, 6);
    chk("we_lat", 64'(lat), 64'd13);

    // address wrap
    run_drain(MEM_N - 2, 4, 0, -1, -1, -1, lat);
    check_beats("wrap", MEM_N - 2, 4);
    chk("wrap_lat", 64'(lat), 64'd8);

    // zero count
    run_drain(7, 0, 0, -1, -1, -1, lat);
    check_beats("zero", 7, 0);
    chk("zero_lat", 64'(lat), 64'd1);

    // start while busy is ignored
    run_drain(50, 4, 0, -1, -1, 2, lat);
    check_beats("busy_start", 50, 4);
    chk("busy_start_lat", 64'(lat), 64'd8);
    chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);

    // reset mid-drain
    beats.delete();
    done_cnt     = 0;
    base_addr_in = ADDR_W'(20);
    count_in     = (ADDR_W+1)'(8);
    start_in     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      start_in = 1'b0;
      if (beats.size() >= 2) break;
    end
    chk("mid_two_beats", 64'(beats.size() >= 2), 64'd1);
    if (beats.size() >= 2) begin
      chk("mid_beat0", 64'(beats[0]), {31'd0, 1'b0, 32'h114});
      chk("mid_beat1", 64'(beats[1]), {31'd0, 1'b0, 32'h115});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    run_drain(40, 2, 0, -1, -1, -1, lat);
    check_beats("after_rst", 40, 2);
    chk("after_rst_lat", 64'(lat), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
